// File: rtl/bubble_sort_ctrl.sv
// Step-paced bubble sort sequencer for the bar-chart display.
// One compare or one swap per step_tick. The live array and the active pair are exported.
module bubble_sort_ctrl #(
  parameter int unsigned N  = 5,
  parameter int unsigned W  = 7,
  parameter int unsigned CW = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   step_tick,
  input  logic [N*W-1:0]         init_values,
  output logic [N*W-1:0]         values,
  output logic [$clog2(N)-1:0]   cmp_idx,
  output logic                   cmp_valid,
  output logic                   swapping,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(N)-1:0]   pass_idx,
  output logic [CW-1:0]          swap_count
);

  localparam int unsigned IW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_SWAP,
    S_DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   arr [N];
  logic           swapped;

  logic [IW-1:0]  nxt_idx_c;
  logic           gt_c;
  logic           end_of_pass_c;
  logic           last_pass_c;
  logic           finish_c;

  for (genvar k = 0; k < N; k++) begin : g_values
    assign values[k*W +: W] = arr[k];
  end

  // Pair compare and end-of-pass decisions for the current j/pass
  assign nxt_idx_c     = cmp_idx + IW'(1);
  assign gt_c          = arr[cmp_idx] > arr[nxt_idx_c];
  assign end_of_pass_c = (32'(cmp_idx) + 32'd1) >= (32'(N) - 32'd1 - 32'(pass_idx));
  assign last_pass_c   = (pass_idx == IW'(N - 2));
  // A swap on this tick counts as "swapped" for the end-of-pass decision
  assign finish_c      = !(swapped || (state == S_SWAP)) || last_pass_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      for (int k = 0; k < N; k++) arr[k] <= '0;
      swapped    <= 1'b0;
      cmp_idx    <= '0;
      pass_idx   <= '0;
      swap_count <= '0;
      cmp_valid  <= 1'b0;
      swapping   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            for (int k = 0; k < N; k++) arr[k] <= init_values[k*W +: W];
            swapped    <= 1'b0;
            cmp_idx    <= '0;
            pass_idx   <= '0;
            swap_count <= '0;
            state      <= S_COMPARE;
            busy       <= 1'b1;
            done       <= 1'b0;
            cmp_valid  <= 1'b1;
            swapping   <= 1'b0;
          end
        end

        S_COMPARE, S_SWAP: begin
          if (abort) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmp_valid <= 1'b0;
            swapping  <= 1'b0;
          end else if (step_tick) begin
            if ((state == S_COMPARE) && gt_c) begin
              state    <= S_SWAP;
              swapping <= 1'b1;
            end else begin
              if (state == S_SWAP) begin
                arr[cmp_idx]   <= arr[nxt_idx_c];
                arr[nxt_idx_c] <= arr[cmp_idx];
                swapped        <= 1'b1;
                if (swap_count != {CW{1'b1}}) swap_count <= swap_count + CW'(1);
              end
              swapping <= 1'b0;
              // Advance: next pair, next pass, or finish
              if (!end_of_pass_c) begin
                cmp_idx <= nxt_idx_c;
                state   <= S_COMPARE;
              end else if (finish_c) begin
                state     <= S_DONE;
                busy      <= 1'b0;
                done      <= 1'b1;
                cmp_valid <= 1'b0;
              end else begin
                pass_idx <= pass_idx + IW'(1);
                cmp_idx  <= '0;
                swapped  <= 1'b0;
                state    <= S_COMPARE;
              end
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Directed bench for bubble_sort_ctrl: sorted, reverse, equal-key, abort, start-while-busy, async reset.
module tb_bubble_sort_ctrl;

  localparam int unsigned N  = 5;
  localparam int unsigned W  = 7;
  localparam int unsigned CW = 8;
  localparam int unsigned IW = $clog2(N);

  logic            clk;
  logic            reset;
  logic            start;
  logic            abort;
  logic            step_tick;
  logic [N*W-1:0]  init_values;
  logic [N*W-1:0]  values;
  logic [IW-1:0]   cmp_idx;
  logic            cmp_valid;
  logic            swapping;
  logic            busy;
  logic            done;
  logic [IW-1:0]   pass_idx;
  logic [CW-1:0]   swap_count;

  int checks;
  int failures;

  bubble_sort_ctrl #(.N(N), .W(W), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .step_tick   (step_tick),
    .init_values (init_values),
    .values      (values),
    .cmp_idx     (cmp_idx),
    .cmp_valid   (cmp_valid),
    .swapping    (swapping),
    .busy        (busy),
    .done        (done),
    .pass_idx    (pass_idx),
    .swap_count  (swap_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [N*W-1:0] pack(input int a0, input int a1, input int a2,
                                          input int a3, input int a4);
    logic [N*W-1:0] p;
    p = '0;
    p[0*W +: W] = W'(a0);
    p[1*W +: W] = W'(a1);
    p[2*W +: W] = W'(a2);
    p[3*W +: W] = W'(a3);
    p[4*W +: W] = W'(a4);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the given control pulses; outputs are sampled 1ns after the edge
  task automatic cyc(input logic s, input logic a, input logic t);
    start = s; abort = a; step_tick = t;
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0; step_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  logic [N*W-1:0] sorted_v, reverse_v, equal_v, v_snap;
  logic [W-1:0]   aj, aj1;
  logic [7:0]     snap_cnt;
  int             nticks;

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; start = 1'b0; abort = 1'b0; step_tick = 1'b0;
    sorted_v  = pack(10, 20, 30, 40, 50);
    reverse_v = pack(50, 40, 30, 20, 10);
    equal_v   = pack(30, 30, 10, 30, 30);
    init_values = sorted_v;

    // Reset state
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_values", 64'(values), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_cmp_valid", 64'(cmp_valid), 64'(0));
    chk("rst_swap_count", 64'(swap_count), 64'(0));
    ticks(2);
    chk("idle_tick_ignored", 64'(values), 64'(0));

    // Sorted input; a tick coincident with start is ignored
    cyc(1'b1, 1'b0, 1'b1);
    chk("sorted_load", 64'(values), 64'(sorted_v));
    chk("sorted_busy", 64'(busy), 64'(1));
    chk("sorted_cmp_valid", 64'(cmp_valid), 64'(1));
    chk("sorted_start_tick_ignored", 64'(cmp_idx), 64'(0));
    ticks(3);
    chk("sorted_not_done_3", 64'(done), 64'(0));
    chk("sorted_cmp_idx_3", 64'(cmp_idx), 64'(3));
    ticks(1);
    chk("sorted_done_4", 64'(done), 64'(1));
    chk("sorted_busy_4", 64'(busy), 64'(0));
    chk("sorted_swap_count", 64'(swap_count), 64'(0));
    chk("sorted_pass_idx", 64'(pass_idx), 64'(0));
    chk("sorted_values", 64'(values), 64'(sorted_v));
    ticks(2);
    chk("sorted_done_held", 64'(done), 64'(1));

    // Reverse input: 20 ticks, alternating compare->swap
    init_values = reverse_v;
    cyc(1'b1, 1'b0, 1'b0);
    chk("rev_load", 64'(values), 64'(reverse_v));
    chk("rev_done_cleared", 64'(done), 64'(0));
    for (int i = 1; i <= 20; i++) begin
      ticks(1);
      if (i % 2 == 1) chk($sformatf("rev_swapping_%0d", i), 64'(swapping), 64'(1));
      else            chk($sformatf("rev_swapping_%0d", i), 64'(swapping), 64'(0));
      if (i == 2) chk("rev_after_first_swap", 64'(values), 64'(pack(40, 50, 30, 20, 10)));
      if (i == 19) chk("rev_not_done_19", 64'(done), 64'(0));
    end
    chk("rev_done_20", 64'(done), 64'(1));
    chk("rev_values", 64'(values), 64'(sorted_v));
    chk("rev_swap_count", 64'(swap_count), 64'(10));
    chk("rev_pass_idx", 64'(pass_idx), 64'(3));

    // Equal keys: no swap on equal pair, 11 ticks, 2 swaps
    init_values = equal_v;
    cyc(1'b1, 1'b0, 1'b0);
    nticks = 0;
    while (!done && nticks < 30) begin
      aj  = values[32'(cmp_idx)*W +: W];
      aj1 = values[(32'(cmp_idx)+1)*W +: W];
      if (aj == aj1) chk("eq_no_swap_equal_pair", 64'(swapping), 64'(0));
      ticks(1);
      nticks++;
    end
    chk("eq_tick_count", 64'(nticks), 64'(11));
    chk("eq_values", 64'(values), 64'(pack(10, 30, 30, 30, 30)));
    chk("eq_swap_count", 64'(swap_count), 64'(2));
    chk("eq_pass_idx", 64'(pass_idx), 64'(2));

    // Abort after 7 ticks of a reverse sort
    init_values = reverse_v;
    cyc(1'b1, 1'b0, 1'b0);
    ticks(7);
    chk("abort_pre_values", 64'(values), 64'(pack(40, 30, 20, 50, 10)));
    chk("abort_pre_swapping", 64'(swapping), 64'(1));
    cyc(1'b0, 1'b1, 1'b0);
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_cmp_valid", 64'(cmp_valid), 64'(0));
    chk("abort_swapping", 64'(swapping), 64'(0));
    chk("abort_values", 64'(values), 64'(pack(40, 30, 20, 50, 10)));
    chk("abort_swap_count", 64'(swap_count), 64'(3));
    ticks(3);
    chk("abort_frozen_values", 64'(values), 64'(pack(40, 30, 20, 50, 10)));
    chk("abort_frozen_count", 64'(swap_count), 64'(3));
    cyc(1'b0, 1'b1, 1'b0);
    chk("abort_idle_noeffect", 64'(busy), 64'(0));
    cyc(1'b1, 1'b0, 1'b0);
    chk("abort_reload_values", 64'(values), 64'(reverse_v));
    chk("abort_reload_count", 64'(swap_count), 64'(0));
    chk("abort_reload_busy", 64'(busy), 64'(1));

    // Start while busy ignored (with a tick in the same cycle)
    ticks(2);
    init_values = sorted_v;
    cyc(1'b1, 1'b0, 1'b1);
    chk("busy_start_values", 64'(values), 64'(pack(40, 50, 30, 20, 10)));
    chk("busy_start_swapping", 64'(swapping), 64'(1));
    chk("busy_start_cmp_idx", 64'(cmp_idx), 64'(1));
    // start + abort while busy: abort wins
    cyc(1'b1, 1'b1, 1'b0);
    chk("busy_abort_wins_busy", 64'(busy), 64'(0));
    chk("busy_abort_wins_values", 64'(values), 64'(pack(40, 50, 30, 20, 10)));
    // start + abort in IDLE: start wins
    cyc(1'b1, 1'b1, 1'b0);
    chk("idle_start_wins_busy", 64'(busy), 64'(1));
    chk("idle_start_wins_values", 64'(values), 64'(sorted_v));

    // Asynchronous reset mid-sort, between edges
    init_values = reverse_v;
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    ticks(5);
    snap_cnt = swap_count;
    v_snap   = values;
    chk("areset_pre_count", 64'(snap_cnt), 64'(2));
    chk("areset_pre_values", 64'(v_snap), 64'(pack(40, 30, 50, 20, 10)));
    #2 reset = 1'b0;
    #1;
    chk("areset_values", 64'(values), 64'(0));
    chk("areset_busy", 64'(busy), 64'(0));
    chk("areset_cmp_valid", 64'(cmp_valid), 64'(0));
    chk("areset_swapping", 64'(swapping), 64'(0));
    chk("areset_swap_count", 64'(swap_count), 64'(0));
    chk("areset_cmp_idx", 64'(cmp_idx), 64'(0));
    chk("areset_pass_idx", 64'(pass_idx), 64'(0));
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    ticks(3);
    chk("post_reset_idle_busy", 64'(busy), 64'(0));
    chk("post_reset_idle_values", 64'(values), 64'(0));
    cyc(1'b1, 1'b0, 1'b0);
    chk("post_reset_start", 64'(values), 64'(reverse_v));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
